// File: rtl/matrix_pkg.sv
// rtl/matrix_pkg.sv - shared constants for the matrix storage read path
package matrix_pkg;

    localparam int DATA_SIZE = 16;
    localparam int MAX_LAYER = 5;
    localparam int SIZE      = 3;
    localparam int ROW_W     = DATA_SIZE * SIZE;
    localparam int IDX_W     = 32;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

endpackage

// File: rtl/row_fifo2.sv
// rtl/row_fifo2.sv - two-entry synchronous FIFO holding returned row words
module row_fifo2 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic [W-1:0] push_data_i,
    input  logic         pop_i,
    output logic [W-1:0] head_o,
    output logic         valid_o,
    output logic [1:0]   count_o
);

    logic [W-1:0] mem_q [2];
    logic         wr_ptr_q;
    logic         rd_ptr_q;
    logic [1:0]   count_q;
    logic         do_push;
    logic         do_pop;

    assign do_pop  = pop_i && (count_q != 2'd0);
    assign do_push = push_i && ((count_q != 2'd2) || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign valid_o = (count_q != 2'd0);
    assign count_o = count_q;

    // The reader's credit scheme must never let a push land on a full FIFO
    no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push_i && (count_q == 2'd2) && !pop_i));

endmodule

// File: rtl/matrix_row_reader.sv
// rtl/matrix_row_reader.sv - walks all rows of one layer in matrix_storage and streams them out
module matrix_row_reader
    import matrix_pkg::*;
#(
    parameter int data_size = DATA_SIZE,
    parameter int max_layer = MAX_LAYER,
    parameter int size      = SIZE
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [IDX_W-1:0]          start_layer,
    output logic                      busy,
    output logic                      done,
    output logic                      error,
    output logic                      mem_is_read,
    output logic [IDX_W-1:0]          mem_read_layer_index,
    output logic [IDX_W-1:0]          mem_read_row_index,
    input  logic [data_size*size-1:0] mem_read_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [data_size*size-1:0] out_data,
    output logic [IDX_W-1:0]          out_row_index,
    output logic                      out_last
);

    localparam int RW    = $clog2(size) + 1;
    localparam int ROWW  = data_size * size;
    localparam int PW    = RW + 1 + ROWW;

    logic [1:0]       state_q,        state_d;
    logic [IDX_W-1:0] layer_q,        layer_d;
    logic [RW-1:0]    issue_row_q,    issue_row_d;
    logic             inflight_q,     inflight_d;
    logic [RW-1:0]    inflight_row_q, inflight_row_d;
    logic             done_q,         done_d;
    logic             error_q,        error_d;

    logic             pop;
    logic             issue;
    logic [2:0]       occupancy;
    logic [1:0]       fifo_count;
    logic [PW-1:0]    push_payload;
    logic [PW-1:0]    head;
    logic [RW-1:0]    head_row;

    assign pop = out_valid && out_ready;

    // Rows buffered plus the one in flight, minus the one leaving now, must stay below 2
    assign occupancy = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};
    assign issue     = (state_q == ST_ISSUE) && (occupancy < 3'd2);

    assign push_payload = {inflight_row_q, (inflight_row_q == RW'(size - 1)), mem_read_data};

    row_fifo2 #(
        .W (PW)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (inflight_q),
        .push_data_i (push_payload),
        .pop_i       (pop),
        .head_o      (head),
        .valid_o     (out_valid),
        .count_o     (fifo_count)
    );

    always_comb begin
        state_d        = state_q;
        layer_d        = layer_q;
        issue_row_d    = issue_row_q;
        inflight_d     = issue;
        inflight_row_d = issue ? issue_row_q : inflight_row_q;
        done_d         = 1'b0;
        error_d        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (start_layer < IDX_W'(max_layer)) begin
                        layer_d     = start_layer;
                        issue_row_d = '0;
                        inflight_d  = 1'b0;
                        state_d     = ST_ISSUE;
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end
            ST_ISSUE: begin
                if (issue) begin
                    issue_row_d = issue_row_q + RW'(1);
                    if (issue_row_q == RW'(size - 1)) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                // Finish on the cycle the last buffered row leaves, so busy and done line up
                if (!inflight_q && ((fifo_count == 2'd0) || ((fifo_count == 2'd1) && pop))) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            layer_q        <= '0;
            issue_row_q    <= '0;
            inflight_q     <= 1'b0;
            inflight_row_q <= '0;
            done_q         <= 1'b0;
            error_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            layer_q        <= layer_d;
            issue_row_q    <= issue_row_d;
            inflight_q     <= inflight_d;
            inflight_row_q <= inflight_row_d;
            done_q         <= done_d;
            error_q        <= error_d;
        end
    end

    assign busy                 = (state_q != ST_IDLE);
    assign done                 = done_q;
    assign error                = error_q;
    assign mem_is_read          = issue;
    assign mem_read_layer_index = layer_q;
    assign mem_read_row_index   = (state_q == ST_IDLE) ? '0 : IDX_W'(issue_row_q);

    assign head_row      = head[PW-1 -: RW];
    assign out_last      = head[ROWW];
    assign out_data      = head[ROWW-1:0];
    assign out_row_index = IDX_W'(head_row);

endmodule
